l_inv_transform: RTL
====================

L_INV_TRANSFORM -- requirements
Module: l_inv_transform

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, giving the number of R^-1 rounds applied per clock; legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts in_data.
REQ-006 SHALL have port in_data, input, 128 bits: block a15..a0, with a15 = [127:120] and a0 = [7:0].
REQ-007 SHALL have port out_valid, output, 1 bit: out_data holds the L^-1 result.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer takes out_data.
REQ-009 SHALL have port out_data, output, 128 bits: L^-1(in_data), same byte order as in_data.

Function
REQ-010 SHALL compute L^-1 as 16 successive applications of R^-1.
REQ-011 For state a15..a0, R^-1 SHALL produce {a14..a0, l(a14,a13,..,a0,a15)}, i.e. a left byte shift with the l result in byte 0.
REQ-012 l SHALL be the GF(2^8) sum over x^8+x^7+x^6+x+1 (0x1C3) of coefficients 148,32,133,16,194,192,1,251,1,192,194,16,133,32,148,1 applied to its arguments in order.
REQ-013 SHALL use a three-state FSM, IDLE -> BUSY -> DONE -> IDLE.
REQ-014 In IDLE, in_ready SHALL be 1; in_valid&&in_ready SHALL load in_data into the state register, clear the round counter and enter BUSY.
REQ-015 In BUSY, each clock SHALL apply ROUNDS_PER_CYCLE rounds and add ROUNDS_PER_CYCLE to the 5-bit round counter; in_ready SHALL be 0.
REQ-016 When the counter reaches 16, the FSM SHALL enter DONE; the result SHALL be registered, with no combinational path from in_data to out_data.
REQ-017 Latency SHALL be 16/ROUNDS_PER_CYCLE cycles: out_valid rises on that clock edge after the accepting edge.
REQ-018 In DONE, out_valid SHALL be 1 and out_data SHALL be held stable until out_ready is 1 at an edge; the FSM then returns to IDLE.
REQ-019 in_ready SHALL be 0 in DONE, so in_valid in DONE is ignored; the next block is accepted no earlier than the cycle after output handshake.
REQ-020 in_valid and in_data SHALL be ignored outside IDLE; the in-flight block is not disturbed.
REQ-021 out_valid SHALL be 0 in IDLE and BUSY; out_data SHALL equal the state register in all states and is meaningful only in DONE.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, counter 0, state register 0, out_valid 0, out_data 0 and in_ready 1, independent of clk.
REQ-023 Reset during BUSY or DONE SHALL discard the block without emitting it.
REQ-024 The first acceptance SHALL be possible at the first rising edge after rst deasserts.

Structure
REQ-025 Shared package kuz_pkg SHALL hold: the field polynomial 0x1C3, the 16 l coefficients, constant ROUNDS=16, a 128-bit block typedef and the FSM state enum.
REQ-026 The l function SHALL be one sub-module, kuz_l_func: combinational 16-byte input, 1-byte output, built from constant GF multipliers and XOR; one instance per unrolled round.
REQ-027 Per-constant multiplication SHALL be synthesisable logic or 256-entry tables, with identical results either way.

Verification
REQ-028 in_data=d456584dd0e3e84cc3166e4b7fa2890d -> out_data=64a59400000000000000000000000000; at ROUNDS_PER_CYCLE=1, out_valid rises 16 cycles after acceptance.
REQ-029 in_data=e6a8094fee0aa204fd97bcb0b44b8580 -> 0e93691a0cfc60408b7b68f66b513c13; next block 79d26221b87b584cd42fbc4ffea5de9a -> d456584dd0e3e84cc3166e4b7fa2890d, with back-to-back handshakes and in_ready low until DONE is consumed.
REQ-030 in_data all zeros -> out_data all zeros; hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stay stable, and in_valid pulses during that time are ignored.
REQ-031 Assert rst for one cycle at round 7 of a block -> outputs zero at once, in_ready=1, no out_valid; the next block gives the correct result.
REQ-032 Repeat REQ-028 with ROUNDS_PER_CYCLE=2, 4, 8 and 16 -> identical data, with latency 8, 4, 2 and 1 cycles.

Source files
------------

// File: rtl/kuz_pkg.sv
// Shared definitions for the Kuznyechik linear layer: field, l coefficients,
// block type, FSM state encoding and a constant-friendly GF(2^8) multiplier.
package kuz_pkg;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned ROUNDS  = 16;
    localparam int unsigned CNT_W   = 5;

    // Field polynomial x^8 + x^7 + x^6 + x + 1
    localparam logic [8:0] GF_POLY = 9'h1C3;

    // l coefficients, index 0 applies to the first argument (byte [127:120])
    localparam logic [7:0] L_COEF [ROUNDS] = '{
        8'd148, 8'd32,  8'd133, 8'd16,  8'd194, 8'd192, 8'd1,   8'd251,
        8'd1,   8'd192, 8'd194, 8'd16,  8'd133, 8'd32,  8'd148, 8'd1
    };

    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Shift-and-add GF(2^8) product; with a constant b it folds to XOR logic
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'(GF_POLY) : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/kuz_l_func.sv
// Kuznyechik l function: GF(2^8) weighted sum of 16 bytes.
// Ports:
//   x   : 16 argument bytes, first argument in [127:120]
//   l_c : combinational 1-byte result
module kuz_l_func
    import kuz_pkg::*;
(
    input  logic [BLOCK_W-1:0] x,
    output logic [7:0]         l_c
);

    // Each term multiplies by a package constant, so only XOR networks remain
    always_comb begin
        l_c = '0;
        for (int i = 0; i < int'(ROUNDS); i++) begin
            l_c = l_c ^ gf_mul(x[BLOCK_W-1-BYTE_W*i -: BYTE_W], L_COEF[i]);
        end
    end

endmodule

// File: rtl/l_inv_transform.sv
// Inverse Kuznyechik linear transform L^-1 = (R^-1)^16, iterated over
// ROUNDS_PER_CYCLE unrolled rounds per clock with a valid/ready handshake.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake, in_data = a15..a0 (a15 in [127:120])
//   out_valid/out_ready : output handshake, out_data = L^-1(in_data)
// ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16.
module l_inv_transform
    import kuz_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    block_t           data_q, data_d;
    logic             in_ready_d;
    logic             out_valid_d;
    block_t           round_out;

    // Unrolled R^-1 chain: left byte shift, l(a14..a0,a15) into byte 0
    for (genvar g = 0; g < int'(ROUNDS_PER_CYCLE); g++) begin : g_round
        block_t     din;
        block_t     dout;
        logic [7:0] l_c;

        if (g == 0) begin : g_first
            assign din = data_q;
        end else begin : g_chain
            assign din = g_round[g-1].dout;
        end

        kuz_l_func u_l_func (
            .x   ({din[BLOCK_W-BYTE_W-1:0], din[BLOCK_W-1 -: BYTE_W]}),
            .l_c (l_c)
        );

        assign dout = {din[BLOCK_W-BYTE_W-1:0], l_c};
    end

    assign round_out = g_round[ROUNDS_PER_CYCLE-1].dout;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                data_d = round_out;
                cnt_d  = cnt_q + CNT_W'(ROUNDS_PER_CYCLE);
                if (cnt_d == CNT_W'(ROUNDS)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State, counter, block and handshake flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    // Result is the state register itself, never a path from in_data
    assign out_data = data_q;

endmodule
